// File: rtl/elevator_ctrl_param_if.sv
// elevator_ctrl_param_if
//   Bundles the floor-call inputs and the car status outputs of the
//   elevator controller.
//   Signals:
//     req          floor-call bits, one per floor (driven by the call panel)
//     floor_number current car floor
//     dir          travel direction, 1 = up, 0 = down
//     move         car is travelling between floors
//     door_open    car is stopped with the door open
//     to_go        latched floor calls not yet serviced
//   Modports:
//     slave  - the controller (consumes req, drives status)
//     master - the call panel / car logic (drives req, observes status)
interface elevator_ctrl_param_if #(
  parameter int FLOORS  = 8,
  parameter int FLOOR_W = $clog2(FLOORS)
);
  logic [FLOORS-1:0]  req;
  logic [FLOOR_W-1:0] floor_number;
  logic               dir;
  logic               move;
  logic               door_open;
  logic [FLOORS-1:0]  to_go;

  modport slave (
    input  req,
    output floor_number, dir, move, door_open, to_go
  );

  modport master (
    output req,
    input  floor_number, dir, move, door_open, to_go
  );
endinterface

// File: rtl/elevator_ctrl_param.sv
// elevator_ctrl_param
//   Elevator controller for FLOORS floors with latched floor calls and
//   SCAN scheduling: the car keeps travelling in its current direction
//   while any call lies ahead and only reverses from IDLE.  A shared
//   counter times each floor step (TRAVEL_CYCLES) and each door dwell
//   (DOOR_CYCLES).
//   Ports:
//     clock  rising-edge clock
//     reset  asynchronous, active-high; returns the car to floor 0, dir up
//     bus    elevator_ctrl_param_if.slave (req in; floor_number, dir,
//            move, door_open, to_go out)
module elevator_ctrl_param #(
  parameter int FLOORS        = 8,
  parameter int FLOOR_W       = $clog2(FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  elevator_ctrl_param_if.slave  bus
);

  localparam int CNT_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] TRAVEL_LD = CNT_W'(TRAVEL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DOOR_LD   = CNT_W'(DOOR_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MOVING = 2'd1,
    DOOR   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [FLOOR_W-1:0] floor_q, floor_d;
  logic               dir_q, dir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FLOORS-1:0]  to_go_q, to_go_d;
  logic [FLOORS-1:0]  clr;
  logic [FLOORS-1:0]  req_mask;

  function automatic logic [FLOORS-1:0] onehot(input logic [FLOOR_W-1:0] f);
    logic [FLOORS-1:0] v;
    v    = '0;
    v[f] = 1'b1;
    return v;
  endfunction

  // True when any pending call lies strictly beyond fl in direction up.
  function automatic logic ahead(input logic [FLOORS-1:0]  pend,
                                 input logic [FLOOR_W-1:0] fl,
                                 input logic               up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (pend[i] && (up ? (FLOOR_W'(i) > fl) : (FLOOR_W'(i) < fl)))
        hit = 1'b1;
    end
    return hit;
  endfunction

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    dir_d    = dir_q;
    cnt_d    = cnt_q;
    clr      = '0;
    req_mask = '1;
    case (state_q)
      IDLE: begin
        if (|to_go_q) begin
          if (to_go_q[floor_q]) begin
            state_d = DOOR;
            cnt_d   = DOOR_LD;
            clr     = onehot(floor_q);
          end else begin
            // Nothing ahead means every call is behind: reverse here,
            // the only place a reversal is allowed.
            state_d = MOVING;
            cnt_d   = TRAVEL_LD;
            if (!ahead(to_go_q, floor_q, dir_q))
              dir_d = ~dir_q;
          end
        end
      end
      MOVING: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          floor_d = dir_q ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);
          if (to_go_q[floor_d]) begin
            state_d = DOOR;
            cnt_d   = DOOR_LD;
            clr     = onehot(floor_d);
          end else begin
            cnt_d = TRAVEL_LD;
          end
        end
      end
      DOOR: begin
        // A call for the floor the door is open at just holds the door;
        // it is never latched as a new request.
        if (bus.req[floor_q]) begin
          cnt_d    = DOOR_LD;
          req_mask = ~onehot(floor_q);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Service clear wins over a same-edge call for the serviced floor.
    to_go_d = (to_go_q | (bus.req & req_mask)) & ~clr;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      floor_q <= '0;
      dir_q   <= 1'b1;
      cnt_q   <= '0;
      to_go_q <= '0;
    end else begin
      state_q <= state_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      to_go_q <= to_go_d;
    end
  end

  assign bus.floor_number = floor_q;
  assign bus.dir          = dir_q;
  assign bus.move         = (state_q == MOVING);
  assign bus.door_open    = (state_q == DOOR);
  assign bus.to_go        = to_go_q;

endmodule

// File: tb/tb_elevator_ctrl_param.sv
// tb_elevator_ctrl_param
//   Directed bench for elevator_ctrl_param (FLOORS=8, TRAVEL=4, DOOR=3).
//   Expected car snapshots {to_go, floor, dir, move, door_open} are queued
//   with the edge they belong to when a stimulus is applied, and compared
//   on the falling edge after that rising edge.
module tb_elevator_ctrl_param;
  localparam int FLOORS  = 8;
  localparam int FLOOR_W = 3;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  elevator_ctrl_param_if #(.FLOORS(FLOORS), .FLOOR_W(FLOOR_W)) bus ();

  elevator_ctrl_param #(
    .FLOORS(FLOORS), .FLOOR_W(FLOOR_W), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    int          at;
    int          tag;
    logic [13:0] v;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  int          edge_n   = 0;
  int          base     = 0;
  logic [2:0]  max_fl   = '0;
  bit          track    = 1'b0;

  function automatic logic [13:0] snap(input logic [7:0] tg, input logic [2:0] fl,
                                       input logic dr, input logic mv, input logic dq);
    return {tg, fl, dr, mv, dq};
  endfunction

  function automatic logic [13:0] cur();
    return snap(bus.to_go, bus.floor_number, bus.dir, bus.move, bus.door_open);
  endfunction

  task automatic chk(input string tag, input logic [13:0] obs, input logic [13:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input int tag, input int at, input logic [13:0] v);
    exp_t e;
    e.at  = at;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    exp_t e;
    repeat (n) begin
      @(posedge clock);
      edge_n++;
      @(negedge clock);
      if (track && bus.floor_number > max_fl) max_fl = bus.floor_number;
      while (sb.size() != 0 && sb[0].at <= edge_n) begin
        e = sb.pop_front();
        if (e.at == edge_n)
          chk($sformatf("sb%0d", e.tag), cur(), e.v);
        else
          chk($sformatf("sb%0d_edge", e.tag), 14'(edge_n), 14'(e.at));
      end
    end
  endtask

  task automatic tick_to(input int e);
    while (edge_n < e) tick(1);
  endtask

  task automatic wait_drain(input int bound, input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < bound) begin
      tick(1);
      k++;
    end
    chk({tag, "_drain"}, 14'(sb.size()), 14'(0));
    sb.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    bus.req = '0;
    tick(2);
    reset = 1'b0;
    #1 chk("reset", cur(), snap(8'h00, 3'd0, 1'b1, 1'b0, 1'b0));

    // single call to floor 3
    base = edge_n;
    push(101, base + 1,  snap(8'h08, 3'd0, 1, 0, 0));
    push(102, base + 2,  snap(8'h08, 3'd0, 1, 1, 0));
    push(103, base + 5,  snap(8'h08, 3'd0, 1, 1, 0));
    push(104, base + 6,  snap(8'h08, 3'd1, 1, 1, 0));
    push(105, base + 10, snap(8'h08, 3'd2, 1, 1, 0));
    push(106, base + 13, snap(8'h08, 3'd2, 1, 1, 0));
    push(107, base + 14, snap(8'h00, 3'd3, 1, 0, 1));
    push(108, base + 16, snap(8'h00, 3'd3, 1, 0, 1));
    push(109, base + 17, snap(8'h00, 3'd3, 1, 0, 0));
    bus.req = 8'h08;
    tick(1);
    bus.req = '0;
    wait_drain(40, "t1");

    // calls to 2 and 5 together from floor 0
    do_reset();
    base = edge_n;
    push(201, base + 1,  snap(8'h24, 3'd0, 1, 0, 0));
    push(202, base + 2,  snap(8'h24, 3'd0, 1, 1, 0));
    push(203, base + 6,  snap(8'h24, 3'd1, 1, 1, 0));
    push(204, base + 10, snap(8'h20, 3'd2, 1, 0, 1));
    push(205, base + 12, snap(8'h20, 3'd2, 1, 0, 1));
    push(206, base + 13, snap(8'h20, 3'd2, 1, 0, 0));
    push(207, base + 14, snap(8'h20, 3'd2, 1, 1, 0));
    push(208, base + 26, snap(8'h00, 3'd5, 1, 0, 1));
    push(209, base + 29, snap(8'h00, 3'd5, 1, 0, 0));
    bus.req = 8'h24;
    tick(1);
    bus.req = '0;
    wait_drain(60, "t2");

    // heading for 6, call to 1 arrives while passing 4
    do_reset();
    base   = edge_n;
    max_fl = '0;
    track  = 1'b1;
    push(301, base + 18, snap(8'h40, 3'd4, 1, 1, 0));
    push(302, base + 20, snap(8'h42, 3'd4, 1, 1, 0));
    push(303, base + 26, snap(8'h02, 3'd6, 1, 0, 1));
    push(304, base + 29, snap(8'h02, 3'd6, 1, 0, 0));
    push(305, base + 30, snap(8'h02, 3'd6, 0, 1, 0));
    push(306, base + 34, snap(8'h02, 3'd5, 0, 1, 0));
    push(307, base + 50, snap(8'h00, 3'd1, 0, 0, 1));
    push(308, base + 53, snap(8'h00, 3'd1, 0, 0, 0));
    bus.req = 8'h40;
    tick(1);
    bus.req = '0;
    tick_to(base + 19);
    bus.req = 8'h02;
    tick(1);
    bus.req = '0;
    wait_drain(80, "t3");
    track = 1'b0;
    chk("t3_maxfloor", 14'(max_fl), 14'(6));

    // call at the current floor, then re-call while the door is open
    base = edge_n;
    push(401, base + 1, snap(8'h02, 3'd1, 0, 0, 0));
    push(402, base + 2, snap(8'h00, 3'd1, 0, 0, 1));
    push(403, base + 3, snap(8'h00, 3'd1, 0, 0, 1));
    push(404, base + 5, snap(8'h00, 3'd1, 0, 0, 1));
    push(405, base + 6, snap(8'h00, 3'd1, 0, 0, 0));
    push(406, base + 7, snap(8'h00, 3'd1, 0, 0, 0));
    bus.req = 8'h02;
    tick(1);
    bus.req = '0;
    tick_to(base + 2);
    bus.req = 8'h02;
    tick(1);
    bus.req = '0;
    wait_drain(20, "t4");

    // asynchronous reset while moving at floor 3
    base = edge_n;
    push(501, base + 1,  snap(8'h20, 3'd1, 0, 0, 0));
    push(502, base + 2,  snap(8'h20, 3'd1, 1, 1, 0));
    push(503, base + 6,  snap(8'h20, 3'd2, 1, 1, 0));
    push(504, base + 10, snap(8'h20, 3'd3, 1, 1, 0));
    bus.req = 8'h20;
    tick(1);
    bus.req = '0;
    tick_to(base + 11);
    #1 chk("t5_pre", cur(), snap(8'h20, 3'd3, 1, 1, 0));
    reset = 1'b1;
    #1 chk("t5_async", cur(), snap(8'h00, 3'd0, 1, 0, 0));
    tick(1);
    reset = 1'b0;
    wait_drain(2, "t5");

    // arrival at 2 with calls for 2 and 7 on the same edge
    base = edge_n;
    push(601, base + 9,  snap(8'h04, 3'd1, 1, 1, 0));
    push(602, base + 10, snap(8'h80, 3'd2, 1, 0, 1));
    push(603, base + 13, snap(8'h80, 3'd2, 1, 0, 0));
    push(604, base + 14, snap(8'h80, 3'd2, 1, 1, 0));
    push(605, base + 34, snap(8'h00, 3'd7, 1, 0, 1));
    push(606, base + 37, snap(8'h00, 3'd7, 1, 0, 0));
    bus.req = 8'h04;
    tick(1);
    bus.req = '0;
    tick_to(base + 9);
    bus.req = 8'h84;
    tick(1);
    bus.req = '0;
    wait_drain(60, "t6");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
